wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback stage and a long-latency unit (mul/div) that returns results out of band.
- The pipeline writeback has priority; long-latency results queue in a small FIFO and drain into idle writeback slots.
- A starvation counter forces a one-cycle pipeline stall so queued results always retire.
- Sits between the MEM/WB pipeline register and the register file write port.

Parameters:
- FIFO_DEPTH, 4: long-latency result queue entries; power of two, ≥2.
- STARVE_LIMIT, 8: cycles a non-empty FIFO head may wait before a forced stall; ≥2.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_regs_write  in  1  writeback stage requests a register write
- wb_rd  in  5  writeback destination register
- wb_wdata  in  32  writeback data (already mem/alu muxed)
- lu_valid  in  1  long-latency unit result valid
- lu_rd  in  5  long-latency result destination
- lu_wdata  in  32  long-latency result data
- lu_ready  out  1  arbiter can accept a long-latency result this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- wb_stall_req  out  1  registered; pipeline must freeze MEM/WB and earlier stages this cycle
- fifo_count  out  clog2(FIFO_DEPTH)+1  queued result count

Behaviour:
- Reset (rst=1 at edge): FIFO empty, rd/wr pointers 0, starve counter 0, FSM=S_PIPE, wb_stall_req=0.
- While rst=1: rf_we=0, lu_ready=0. A reset mid-operation discards queued results.
- Accept: lu_ready = !rst && (fifo_count != FIFO_DEPTH), derived from the current count only.
  - When full, a same-cycle pop does not open a slot.
  - lu_valid && lu_ready enqueues {lu_rd, lu_wdata}.
  - If lu_rd==0, the handshake completes but nothing is enqueued.
- pipe_wr = wb_regs_write && wb_rd!=0 && !wb_stall_req. Writes to x0 are never issued.
- Port select (combinational, same cycle as inputs):
  - pipe_wr: rf = {1, wb_rd, wb_wdata}.
  - else FIFO non-empty: rf = {1, head.rd, head.wdata}, head popped at edge.
  - else rf_we=0.
  - rf_waddr and rf_wdata are 0 whenever rf_we=0.
- Latency: an enqueued result is writable at the earliest the cycle after acceptance, unless WB_BYPASS_EN applies.
- Push and pop in the same cycle: fifo_count unchanged, pointers wrap modulo FIFO_DEPTH.
- Starve counter:
  - Cleared when the FIFO is empty or the head is popped.
  - Otherwise increments by 1, saturating at STARVE_LIMIT-1.
- FSM:
  - S_PIPE to S_FORCE when the counter == STARVE_LIMIT-1, the FIFO is non-empty and there is no pop this cycle.
  - S_FORCE: wb_stall_req=1. Pipeline write suppressed; the held instruction is retried next cycle. Head popped unconditionally (FIFO is guaranteed non-empty). Counter cleared.
  - S_FORCE always returns to S_PIPE after one cycle. wb_stall_req is never asserted two consecutive cycles.
- Ordering:
  - FIFO drains in acceptance order.
  - No WAW ordering between pipeline and queue; the issue scoreboard guarantees no overlapping rd between in-flight long-latency ops and younger instructions.

Optional Feature:
- WB_BYPASS_EN, defined:
  - When the FIFO is empty, pipe_wr=0, wb_stall_req=0, lu_valid=1 and lu_rd!=0, the result is written to rf directly that cycle and not enqueued.
  - Zero-latency retire.
- WB_BYPASS_EN undefined: every accepted result goes through the FIFO, minimum 1-cycle latency.

Test Plan:
- Reset: assert rst 2 cycles with lu_valid=1 and wb_regs_write=1 -> rf_we=0, lu_ready=0, fifo_count=0, wb_stall_req=0. First cycle after release, pipe wb_rd=5/0xA5A5A5A5 -> rf_we=1, waddr=5.
- Idle drain: lu result rd=7/0x12345678 with pipeline idle -> fifo_count=1 next cycle, then rf write x7=0x12345678 and fifo_count=0. With WB_BYPASS_EN: written the same cycle, fifo_count stays 0.
- Priority and full: pipeline writes every cycle; push 4 results rd=1..4 -> lu_ready=0 after the 4th. Further lu_valid is held off. Only pipeline writes appear on rf.
- Starvation: continuous pipeline writes with one queued result -> wb_stall_req=1 exactly STARVE_LIMIT cycles after enqueue, for one cycle, during which rf writes the queued rd. Held pipeline rd is written the following cycle.
- x0 filtering: wb_rd=0 with wb_regs_write=1 -> rf_we=0. lu_rd=0 accepted -> fifo_count unchanged.
- Mid-run reset: 3 entries queued, rst for 1 cycle -> fifo_count=0, none of the 3 results ever appear on rf.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results queue
// in a FIFO and drain into idle slots. Optional macro WB_BYPASS_EN enables zero-latency retire.
module wb_port_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wb_regs_write,
   input  logic [4:0]                    wb_rd,
   input  logic [31:0]                   wb_wdata,
   input  logic                          lu_valid,
   input  logic [4:0]                    lu_rd,
   input  logic [31:0]                   lu_wdata,
   output logic                          lu_ready,
   output logic                          rf_we,
   output logic [4:0]                    rf_waddr,
   output logic [31:0]                   rf_wdata,
   output logic                          wb_stall_req,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(STARVE_LIMIT);
   localparam logic [PW:0]   FullCount = (PW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] StarveMax = CW'(STARVE_LIMIT - 1);

   typedef enum logic [0:0] {S_PIPE, S_FORCE} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [CW-1:0] starve_q, starve_d;

   logic [4:0]    rd_mem   [FIFO_DEPTH];
   logic [31:0]   data_mem [FIFO_DEPTH];

   logic fifo_empty, fifo_full, stall, pipe_wr, bypass, push, pop;

   assign fifo_empty   = (count_q == '0);
   assign fifo_full    = (count_q == FullCount);
   assign stall        = (state_q == S_FORCE);
   assign wb_stall_req = stall;
   assign fifo_count   = count_q;
   // Readiness looks only at the current count, so a pop cannot free a slot in the same cycle.
   assign lu_ready     = !rst && !fifo_full;
   assign pipe_wr      = wb_regs_write && (wb_rd != 5'd0) && !stall;

`ifdef WB_BYPASS_EN
   assign bypass = !rst && fifo_empty && !pipe_wr && !stall && lu_valid && (lu_rd != 5'd0);
`else
   assign bypass = 1'b0;
`endif

   // x0 results complete the handshake but are dropped.
   assign push = lu_valid && lu_ready && (lu_rd != 5'd0) && !bypass;

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      pop      = 1'b0;
      if (!rst) begin
         if (pipe_wr) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_wdata;
         end else if (!fifo_empty) begin
            rf_we    = 1'b1;
            rf_waddr = rd_mem[rd_ptr_q];
            rf_wdata = data_mem[rd_ptr_q];
            pop      = 1'b1;
         end else if (bypass) begin
            rf_we    = 1'b1;
            rf_waddr = lu_rd;
            rf_wdata = lu_wdata;
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      starve_d = starve_q;
      state_d  = state_q;

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + (PW + 1)'(1);
      else if (!push && pop) count_d = count_q - (PW + 1)'(1);

      if (fifo_empty || pop)      starve_d = '0;
      else if (starve_q != StarveMax) starve_d = starve_q + CW'(1);

      unique case (state_q)
         S_PIPE: begin
            if ((starve_q == StarveMax) && !fifo_empty && !pop) state_d = S_FORCE;
         end
         // The stall suppresses pipe_wr, so the head drains through the normal select path.
         S_FORCE: state_d = S_PIPE;
         default: state_d = S_PIPE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_PIPE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr_q]   <= lu_rd;
         data_mem[wr_ptr_q] <= lu_wdata;
      end
   end

endmodule
